// File: rtl/lcd_update_sched_if.sv
// Bundle of request, SPI byte stream, pixel fetch and status signals for lcd_update_sched.
// The scheduler sits on the slave side; the client driving requests and pixels is the master.
interface lcd_update_sched_if;
  logic        req_valid;
  logic        req_ready;
  logic [7:0]  req_x0;
  logic [7:0]  req_x1;
  logic [7:0]  req_y0;
  logic [7:0]  req_y1;
  logic        byte_valid;
  logic        byte_ready;
  logic [7:0]  byte_data;
  logic        byte_dc;
  logic [7:0]  pix_x;
  logic [7:0]  pix_y;
  logic [15:0] pix_value;
  logic        busy;
  logic        done;
  logic        err;

  modport master (
    output req_valid, req_x0, req_x1, req_y0, req_y1, byte_ready, pix_value,
    input  req_ready, byte_valid, byte_data, byte_dc, pix_x, pix_y, busy, done, err
  );

  modport slave (
    input  req_valid, req_x0, req_x1, req_y0, req_y1, byte_ready, pix_value,
    output req_ready, byte_valid, byte_data, byte_dc, pix_x, pix_y, busy, done, err
  );
endinterface

// File: rtl/lcd_update_sched.sv
// Turns a rectangle update request into the CASET/RASET/RAMWR command stream
// followed by RGB565 pixel bytes fetched one pixel at a time.
module lcd_update_sched #(
  parameter int unsigned H_RES   = 240,
  parameter int unsigned V_RES   = 135,
  parameter int unsigned COL_OFS = 40,
  parameter int unsigned ROW_OFS = 53
) (
  input  logic               clk,
  input  logic               resetn,
  lcd_update_sched_if.slave  bus
);

  localparam logic [15:0] COL_OFS16 = COL_OFS[15:0];
  localparam logic [15:0] ROW_OFS16 = ROW_OFS[15:0];

  typedef enum logic [2:0] {IDLE, CASET, RASET, RAMWR, PIX_HI, PIX_LO, DONE} state_t;

  state_t      state, state_next;
  logic [7:0]  x0, x1, y0, y1;
  logic [7:0]  pix_x, pix_y;
  logic [7:0]  lo_byte;
  logic [2:0]  idx;
  logic        err_q;
  logic        accept, req_bad, xfer, last_col, last_pix;
  logic [15:0] win_start, win_end;
  logic [7:0]  win_cmd;

  // Acceptance is derived from state rather than req_ready to keep the comb block loop-free.
  assign accept   = bus.req_valid && resetn && (state == IDLE);
  assign req_bad  = (bus.req_x0 > bus.req_x1) || (bus.req_y0 > bus.req_y1) ||
                    (32'(bus.req_x1) >= H_RES) || (32'(bus.req_y1) >= V_RES);
  assign xfer     = bus.byte_valid && bus.byte_ready;
  assign last_col = (pix_x == x1);
  assign last_pix = last_col && (pix_y == y1);

  assign bus.pix_x = pix_x;
  assign bus.pix_y = pix_y;
  assign bus.err   = err_q;

  always_ff @(posedge clk) begin
    if (!resetn) state <= IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next     = state;
    bus.req_ready  = 1'b0;
    bus.byte_valid = 1'b0;
    bus.byte_data  = 8'h00;
    bus.byte_dc    = 1'b0;
    bus.busy       = 1'b1;
    bus.done       = 1'b0;
    win_cmd        = (state == RASET) ? 8'h2B : 8'h2A;
    win_start      = (state == RASET) ? (16'(y0) + ROW_OFS16) : (16'(x0) + COL_OFS16);
    win_end        = (state == RASET) ? (16'(y1) + ROW_OFS16) : (16'(x1) + COL_OFS16);
    case (state)
      IDLE: begin
        bus.req_ready = resetn;
        bus.busy      = 1'b0;
        if (accept && !req_bad) state_next = CASET;
      end
      CASET, RASET: begin
        bus.byte_valid = 1'b1;
        bus.byte_dc    = 1'b1;
        case (idx)
          3'd0: begin
            bus.byte_data = win_cmd;
            bus.byte_dc   = 1'b0;
          end
          3'd1:    bus.byte_data = win_start[15:8];
          3'd2:    bus.byte_data = win_start[7:0];
          3'd3:    bus.byte_data = win_end[15:8];
          default: bus.byte_data = win_end[7:0];
        endcase
        if (bus.byte_ready && idx == 3'd4) state_next = (state == CASET) ? RASET : RAMWR;
      end
      RAMWR: begin
        bus.byte_valid = 1'b1;
        bus.byte_data  = 8'h2C;
        if (bus.byte_ready) state_next = PIX_HI;
      end
      PIX_HI: begin
        bus.byte_valid = 1'b1;
        bus.byte_data  = bus.pix_value[15:8];
        bus.byte_dc    = 1'b1;
        if (bus.byte_ready) state_next = PIX_LO;
      end
      PIX_LO: begin
        bus.byte_valid = 1'b1;
        bus.byte_data  = lo_byte;
        bus.byte_dc    = 1'b1;
        if (bus.byte_ready) state_next = last_pix ? DONE : PIX_HI;
      end
      DONE: begin
        bus.done   = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Window latch, command byte index and raster walk; pixel coordinates only move after the low byte.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      x0      <= 8'h00;
      x1      <= 8'h00;
      y0      <= 8'h00;
      y1      <= 8'h00;
      pix_x   <= 8'h00;
      pix_y   <= 8'h00;
      lo_byte <= 8'h00;
      idx     <= 3'd0;
      err_q   <= 1'b0;
    end else begin
      err_q <= accept && req_bad;
      if (accept && !req_bad) begin
        x0  <= bus.req_x0;
        x1  <= bus.req_x1;
        y0  <= bus.req_y0;
        y1  <= bus.req_y1;
        idx <= 3'd0;
      end
      if ((state == CASET || state == RASET) && xfer) idx <= (idx == 3'd4) ? 3'd0 : idx + 3'd1;
      if (state == RAMWR && xfer) begin
        pix_x <= x0;
        pix_y <= y0;
      end
      if (state == PIX_HI && xfer) lo_byte <= bus.pix_value[7:0];
      if (state == PIX_LO && xfer && !last_pix) begin
        if (last_col) begin
          pix_x <= x0;
          pix_y <= pix_y + 8'd1;
        end else begin
          pix_x <= pix_x + 8'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_lcd_update_sched.sv
// Scoreboard bench for lcd_update_sched: expected byte streams are queued per request
// and compared against every accepted byte by a negedge monitor.
module tb_lcd_update_sched;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  lcd_update_sched_if bus();

  int tests_run = 0;
  int tests_failed = 0;
  logic [8:0] exp_q[$];
  int byte_cnt = 0;
  int done_cnt = 0;
  int cyc = 0;
  int last_acc_cyc = 0;
  int done_cyc = 0;
  int stall_checks = 0;
  logic prev_stall = 1'b0;
  logic [8:0] prev_byte = 9'h0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Pixel source: high byte is the column, low byte a scrambled row, so order errors show up.
  assign bus.pix_value = {bus.pix_x, bus.pix_y ^ 8'h5A};

  lcd_update_sched dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  always @(negedge clk) begin
    logic [8:0] exp_b;
    logic [8:0] got_b;
    got_b = {bus.byte_dc, bus.byte_data};
    if (resetn) begin
      if (prev_stall && bus.byte_valid === 1'b1) begin
        stall_checks++;
        tests_run++;
        if (got_b !== prev_byte) begin
          tests_failed++;
          $display("[TB] FAIL stall_stable: got %h, want %h", got_b, prev_byte);
        end
      end
      if (bus.byte_valid === 1'b1 && bus.byte_ready === 1'b1) begin
        byte_cnt++;
        last_acc_cyc = cyc;
        tests_run++;
        if (exp_q.size() == 0) begin
          tests_failed++;
          $display("[TB] FAIL unexpected_byte: got %h, want no byte", got_b);
        end else begin
          exp_b = exp_q.pop_front();
          if (got_b !== exp_b) begin
            tests_failed++;
            $display("[TB] FAIL byte_stream: got dc/data %h, want %h", got_b, exp_b);
          end
        end
      end
      if (bus.done === 1'b1) begin
        done_cnt++;
        done_cyc = cyc;
      end
      prev_stall = (bus.byte_valid === 1'b1) && (bus.byte_ready !== 1'b1);
      prev_byte  = got_b;
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic push_expected(input int x0, input int x1, input int y0, input int y1);
    int cs, ce, rs, re;
    cs = x0 + 40;
    ce = x1 + 40;
    rs = y0 + 53;
    re = y1 + 53;
    exp_q.push_back({1'b0, 8'h2A});
    exp_q.push_back({1'b1, cs[15:8]});
    exp_q.push_back({1'b1, cs[7:0]});
    exp_q.push_back({1'b1, ce[15:8]});
    exp_q.push_back({1'b1, ce[7:0]});
    exp_q.push_back({1'b0, 8'h2B});
    exp_q.push_back({1'b1, rs[15:8]});
    exp_q.push_back({1'b1, rs[7:0]});
    exp_q.push_back({1'b1, re[15:8]});
    exp_q.push_back({1'b1, re[7:0]});
    exp_q.push_back({1'b0, 8'h2C});
    for (int y = y0; y <= y1; y++) begin
      for (int x = x0; x <= x1; x++) begin
        exp_q.push_back({1'b1, 8'(x)});
        exp_q.push_back({1'b1, 8'(y) ^ 8'h5A});
      end
    end
  endtask

  task automatic send_req(input logic [7:0] x0, input logic [7:0] x1,
                          input logic [7:0] y0, input logic [7:0] y1);
    @(posedge clk);
    #1;
    bus.req_x0    = x0;
    bus.req_x1    = x1;
    bus.req_y0    = y0;
    bus.req_y1    = y1;
    bus.req_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string name);
    bit found;
    found = 1'b0;
    for (int n = 0; n < budget && !found; n++) begin
      @(negedge clk);
      if (bus.done === 1'b1) found = 1'b1;
    end
    #1;
    tests_run++;
    if (!found) begin
      tests_failed++;
      $display("[TB] FAIL %s_timeout: got no done, want done within %0d cycles", name, budget);
    end
  endtask

  task automatic check_count(input int got, input int want, input string name);
    tests_run++;
    if (got !== want) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d, want %0d", name, got, want);
    end
  endtask

  task automatic test_reset();
    resetn        = 1'b0;
    bus.byte_ready = 1'b1;
    bus.req_x0    = 8'd3;
    bus.req_x1    = 8'd3;
    bus.req_y0    = 8'd5;
    bus.req_y1    = 8'd5;
    bus.req_valid = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    tests_run++;
    if ({bus.req_ready, bus.byte_valid, bus.byte_dc, bus.busy, bus.done, bus.err} !== 6'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_flags: got %b, want 000000",
               {bus.req_ready, bus.byte_valid, bus.byte_dc, bus.busy, bus.done, bus.err});
    end
    tests_run++;
    if ({bus.byte_data, bus.pix_x, bus.pix_y} !== 24'h0) begin
      tests_failed++;
      $display("[TB] FAIL reset_data: got %h, want 000000", {bus.byte_data, bus.pix_x, bus.pix_y});
    end
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    resetn        = 1'b1;
    @(negedge clk);
    tests_run++;
    if ({bus.req_ready, bus.busy} !== 2'b10) begin
      tests_failed++;
      $display("[TB] FAIL reset_release: got ready/busy %b, want 10", {bus.req_ready, bus.busy});
    end
  endtask

  task automatic test_single_pixel();
    int b0;
    b0 = byte_cnt;
    push_expected(3, 3, 5, 5);
    send_req(8'd3, 8'd3, 8'd5, 8'd5);
    wait_done(200, "single");
    check_count(byte_cnt - b0, 13, "single_bytes");
    check_count(done_cyc - last_acc_cyc, 1, "single_done_latency");
    check_count(exp_q.size(), 0, "single_queue_left");
    @(negedge clk);
    tests_run++;
    if ({bus.done, bus.busy, bus.req_ready} !== 3'b001) begin
      tests_failed++;
      $display("[TB] FAIL single_done_pulse: got done/busy/ready %b, want 001",
               {bus.done, bus.busy, bus.req_ready});
    end
  endtask

  task automatic test_full_frame();
    int b0;
    b0 = byte_cnt;
    push_expected(0, 239, 0, 134);
    send_req(8'd0, 8'd239, 8'd0, 8'd134);
    wait_done(70000, "frame");
    check_count(byte_cnt - b0, 64811, "frame_bytes");
    check_count(exp_q.size(), 0, "frame_queue_left");
  endtask

  task automatic test_stalls();
    int b0, s0;
    bit found;
    b0 = byte_cnt;
    s0 = stall_checks;
    found = 1'b0;
    push_expected(10, 13, 20, 21);
    send_req(8'd10, 8'd13, 8'd20, 8'd21);
    for (int n = 0; n < 2000 && !found; n++) begin
      @(posedge clk);
      #1;
      bus.byte_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (bus.done === 1'b1) found = 1'b1;
    end
    bus.byte_ready = 1'b1;
    #1;
    tests_run++;
    if (!found) begin
      tests_failed++;
      $display("[TB] FAIL stall_timeout: got no done, want done within 2000 cycles");
    end
    check_count(byte_cnt - b0, 27, "stall_bytes");
    check_count(exp_q.size(), 0, "stall_queue_left");
    tests_run++;
    if (stall_checks == s0) begin
      tests_failed++;
      $display("[TB] FAIL stall_seen: got 0 stalled cycles, want at least 1");
    end
  endtask

  task automatic test_invalid();
    logic [7:0] bad[3][4];
    bad[0] = '{8'd0, 8'd240, 8'd0, 8'd0};
    bad[1] = '{8'd9, 8'd8,   8'd0, 8'd0};
    bad[2] = '{8'd0, 8'd0,   8'd0, 8'd135};
    for (int i = 0; i < 3; i++) begin
      send_req(bad[i][0], bad[i][1], bad[i][2], bad[i][3]);
      @(negedge clk);
      tests_run++;
      if ({bus.err, bus.byte_valid, bus.busy} !== 3'b100) begin
        tests_failed++;
        $display("[TB] FAIL invalid%0d_pulse: got err/valid/busy %b, want 100", i,
                 {bus.err, bus.byte_valid, bus.busy});
      end
      @(negedge clk);
      tests_run++;
      if ({bus.err, bus.byte_valid, bus.busy} !== 3'b000) begin
        tests_failed++;
        $display("[TB] FAIL invalid%0d_after: got err/valid/busy %b, want 000", i,
                 {bus.err, bus.byte_valid, bus.busy});
      end
    end
  endtask

  task automatic test_reset_mid();
    int b0;
    bit found;
    b0 = byte_cnt;
    found = 1'b0;
    push_expected(0, 3, 0, 1);
    send_req(8'd0, 8'd3, 8'd0, 8'd1);
    // The 14th byte is the high half of the second pixel, so the next cycle is PIX_LO.
    for (int n = 0; n < 200 && !found; n++) begin
      @(negedge clk);
      #1;
      if (byte_cnt - b0 == 14) found = 1'b1;
    end
    tests_run++;
    if (!found) begin
      tests_failed++;
      $display("[TB] FAIL midreset_reach: got %0d bytes, want 14", byte_cnt - b0);
    end
    @(posedge clk);
    #1;
    resetn = 1'b0;
    @(posedge clk);
    #1;
    exp_q.delete();
    @(negedge clk);
    tests_run++;
    if ({bus.byte_valid, bus.busy, bus.done} !== 3'b000) begin
      tests_failed++;
      $display("[TB] FAIL midreset_idle: got valid/busy/done %b, want 000",
               {bus.byte_valid, bus.busy, bus.done});
    end
    @(posedge clk);
    #1;
    resetn = 1'b1;
    @(negedge clk);
    tests_run++;
    if (bus.req_ready !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL midreset_ready: got %b, want 1", bus.req_ready);
    end
    b0 = byte_cnt;
    push_expected(5, 6, 7, 7);
    send_req(8'd5, 8'd6, 8'd7, 8'd7);
    wait_done(200, "midreset_new");
    check_count(byte_cnt - b0, 15, "midreset_new_bytes");
    check_count(exp_q.size(), 0, "midreset_queue_left");
  endtask

  task automatic test_back_to_back();
    int b0, d0;
    b0 = byte_cnt;
    d0 = done_cnt;
    push_expected(1, 2, 1, 1);
    push_expected(1, 2, 1, 1);
    @(posedge clk);
    #1;
    bus.req_x0    = 8'd1;
    bus.req_x1    = 8'd2;
    bus.req_y0    = 8'd1;
    bus.req_y1    = 8'd1;
    bus.req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    tests_run++;
    if ({bus.busy, bus.req_ready} !== 2'b10) begin
      tests_failed++;
      $display("[TB] FAIL b2b_busy: got busy/ready %b, want 10", {bus.busy, bus.req_ready});
    end
    wait_done(200, "b2b_first");
    check_count(byte_cnt - b0, 15, "b2b_first_bytes");
    @(negedge clk);
    tests_run++;
    if ({bus.busy, bus.req_ready} !== 2'b01) begin
      tests_failed++;
      $display("[TB] FAIL b2b_idle: got busy/ready %b, want 01", {bus.busy, bus.req_ready});
    end
    @(negedge clk);
    tests_run++;
    if (bus.busy !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL b2b_restart: got busy %b, want 1", bus.busy);
    end
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    wait_done(200, "b2b_second");
    check_count(byte_cnt - b0, 30, "b2b_total_bytes");
    check_count(done_cnt - d0, 2, "b2b_done_count");
    check_count(exp_q.size(), 0, "b2b_queue_left");
  endtask

  initial begin
    bus.req_valid  = 1'b0;
    bus.req_x0     = 8'd0;
    bus.req_x1     = 8'd0;
    bus.req_y0     = 8'd0;
    bus.req_y1     = 8'd0;
    bus.byte_ready = 1'b1;
    test_reset();
    test_single_pixel();
    test_full_frame();
    test_stalls();
    test_invalid();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/lcd_update_sched.md
LCD_UPDATE_SCHED -- requirements
Module: lcd_update_sched

Interface
REQ-001 SHALL have parameter H_RES, default 240, meaning visible columns.
REQ-002 SHALL have parameter V_RES, default 135, meaning visible rows.
REQ-003 SHALL have parameter COL_OFS, default 40, meaning panel column offset added to x.
REQ-004 SHALL have parameter ROW_OFS, default 53, meaning panel row offset added to y.
REQ-005 SHALL have a single clock and synchronous active-low reset: clk in 1, the only clock, all logic on its rising edge; resetn in 1, synchronous, active-low.
REQ-006 SHALL have ports: req_valid in 1 (rectangle request); req_ready out 1; req_x0/req_x1 in 8 (inclusive columns); req_y0/req_y1 in 8 (inclusive rows).
REQ-007 SHALL have ports: byte_valid out 1; byte_ready in 1; byte_data out 8; byte_dc out 1 (0 = command, 1 = data), driving the SPI byte shifter.
REQ-008 SHALL have ports: pix_x out 8; pix_y out 8 (pixel being fetched); pix_value in 16 (RGB565, combinational from pix_x/pix_y).
REQ-009 SHALL have ports: busy out 1; done out 1 (one-cycle pulse); err out 1 (one-cycle pulse, rejected request).

Function
REQ-010 SHALL drive req_ready=1 only in state IDLE; a request is accepted on req_valid && req_ready.
REQ-011 SHALL reject an accepted request, pulse err for 1 cycle, and stay IDLE, when x0>x1, y0>y1, x1>=H_RES or y1>=V_RES.
REQ-012 SHALL latch x0/x1/y0/y1 of a valid request and enter CASET on the next cycle.
REQ-013 SHALL sequence states IDLE -> CASET -> RASET -> RAMWR -> PIX_HI <-> PIX_LO -> DONE -> IDLE.
REQ-014 SHALL, in CASET, emit 5 bytes: 0x2A (dc=0), then (x0+COL_OFS)[15:8], [7:0], (x1+COL_OFS)[15:8], [7:0] (dc=1), in 16-bit arithmetic.
REQ-015 SHALL, in RASET, emit 0x2A-equivalent sequence with command 0x2B and y0+ROW_OFS, y1+ROW_OFS.
REQ-016 SHALL, in RAMWR, emit single byte 0x2C with dc=0.
REQ-017 SHALL transfer a byte only on byte_valid && byte_ready; byte_data and byte_dc SHALL remain stable while byte_valid=1 and byte_ready=0.
REQ-018 SHALL hold byte_valid=1 throughout CASET, RASET, RAMWR, PIX_HI and PIX_LO, with no bubble between accepted bytes, and 0 in IDLE and DONE.
REQ-019 SHALL, in PIX_HI, drive byte_data=pix_value[15:8], dc=1, and capture pix_value[7:0] on acceptance.
REQ-020 SHALL, in PIX_LO, drive the captured low byte, dc=1.
REQ-021 SHALL initialise pix_x=x0, pix_y=y0 on entry to PIX_HI from RAMWR; pix_x/pix_y SHALL be held constant across a PIX_HI/PIX_LO pair.
REQ-022 SHALL, on PIX_LO acceptance, advance pix_x; at pix_x==x1, wrap pix_x to x0 and increment pix_y.
REQ-023 SHALL go to DONE when the PIX_LO byte of pixel (x1,y1) is accepted.
REQ-024 SHALL pulse done in DONE for exactly one cycle, then return to IDLE.
REQ-025 SHALL emit exactly 11 + 2*(x1-x0+1)*(y1-y0+1) bytes per accepted request.
REQ-026 SHALL drive busy=1 in every state except IDLE.
REQ-027 SHALL ignore req_* inputs outside IDLE; requests are not queued.

Reset
REQ-028 SHALL, on resetn=0 at a rising clk edge, enter IDLE regardless of state, abandoning any in-progress transfer.
REQ-029 SHALL reset outputs to: req_ready=1 (once resetn=1), byte_valid=0, byte_data=0x00, byte_dc=0, pix_x=0, pix_y=0, busy=0, done=0, err=0.
REQ-030 SHALL not start a transfer in the cycle resetn deasserts; the first acceptance is possible one cycle later.

Verification
REQ-031 SHALL verify single-pixel request (3,5,3,5), byte_ready=1 -> bytes 2A,00,2B,00,2B,2C,35+5... i.e. 2A,00,2B,00,2B / 2B,00,3A,00,3A / 2C / pix hi, lo; done 1 cycle after the last byte; 13 bytes.
REQ-032 SHALL verify full frame (0,239,0,134) -> CASET 00,28,01,17; RASET 00,35,00,BB; 64811 bytes; pix_x wraps 239->0 with pix_y increment.
REQ-033 SHALL verify random byte_ready stalls on a 4x2 rectangle -> data/dc stable while stalled; pixel order (x0..x1) per row; 27 bytes.
REQ-034 SHALL verify invalid requests (x1=240; x0=9,x1=8; y1=135) -> err pulse, no byte_valid, busy stays 0.
REQ-035 SHALL verify resetn=0 mid-PIX_LO -> next cycle byte_valid=0, busy=0, state IDLE; a new request afterwards completes normally.
REQ-036 SHALL verify req_valid held high during busy -> no second transfer until IDLE; then accepted back-to-back.
